window_3x3_line_buffer: RTL and testbench



---
 rtl/window_3x3_line_buffer.sv | 134 +++++++++++++
 tb/tb_window_3x3_line_buffer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_line_buffer.sv
// 3x3 sliding-window generator over a raster-order pixel stream.
// Two line buffers hold the previous two rows; a 3x3 shift register forms
// the neighbourhood. Each accepted pixel produces one registered window.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   pix_in     input pixel
//   pix_valid  pix_in is accepted on this edge when high (low = stall)
//   sof        start of frame; the pixel accepted on the same edge is (0,0)
//   win_data   window, tap k at bits [k*PIX_W +: PIX_W]
//              taps 0..2 = row r-2, 3..5 = row r-1, 6..8 = row r; left to right
//   win_valid  one-cycle strobe: window fully inside the frame (r>=2, c>=2)
//   win_col    column of tap 8 for the last accept
//   win_row    row of tap 8 for the last accept
//   frame_done one-cycle pulse after the last pixel of a frame is accepted
module window_3x3_line_buffer #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned COL_W = $clog2(IMG_W),
    parameter int unsigned ROW_W = $clog2(IMG_H)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    input  logic               sof,
    output logic [9*PIX_W-1:0] win_data,
    output logic               win_valid,
    output logic [COL_W-1:0]   win_col,
    output logic [ROW_W-1:0]   win_row,
    output logic               frame_done
);

    localparam int unsigned    N_TAPS   = 9;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;

    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];

    logic [PIX_W-1:0] tap_q [N_TAPS];

    logic [COL_W-1:0] cur_col_c;
    logic [ROW_W-1:0] cur_row_c;
    logic [COL_W-1:0] nxt_col_c;
    logic [ROW_W-1:0] nxt_row_c;
    logic [PIX_W-1:0] lb1_rd_c;
    logic [PIX_W-1:0] lb2_rd_c;
    logic             win_ok_c;
    logic             last_c;

    // Position of this edge's pixel (sof forces 0,0) and the position of the next one.
    always_comb begin
        cur_col_c = sof ? '0 : col_q;
        cur_row_c = sof ? '0 : row_q;
        nxt_col_c = cur_col_c;
        nxt_row_c = cur_row_c;
        if (pix_valid) begin
            if (cur_col_c == COL_LAST) begin
                nxt_col_c = '0;
                nxt_row_c = (cur_row_c == ROW_LAST) ? '0 : cur_row_c + ROW_W'(1);
            end else begin
                nxt_col_c = cur_col_c + COL_W'(1);
            end
        end
    end

    // Read-before-write: the old line contents feed the new window column.
    always_comb begin
        lb1_rd_c = lb1[cur_col_c];
        lb2_rd_c = lb2[cur_col_c];
        win_ok_c = (cur_row_c >= ROW_W'(2)) && (cur_col_c >= COL_W'(2));
        last_c   = (cur_col_c == COL_LAST) && (cur_row_c == ROW_LAST);
    end

    // Position counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= nxt_col_c;
            row_q <= nxt_row_c;
        end
    end

    // Line buffer RAMs; contents are not reset since r restarts at 0 anyway.
    always_ff @(posedge clk) begin
        if (rst_n && pix_valid) begin
            lb2[cur_col_c] <= lb1_rd_c;
            lb1[cur_col_c] <= pix_in;
        end
    end

    // Window shift register and qualifiers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(N_TAPS); k++) begin
                tap_q[k] <= '0;
            end
            win_valid  <= 1'b0;
            win_col    <= '0;
            win_row    <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= pix_valid && win_ok_c;
            frame_done <= pix_valid && last_c;
            if (pix_valid) begin
                tap_q[0] <= tap_q[1];
                tap_q[1] <= tap_q[2];
                tap_q[2] <= lb2_rd_c;
                tap_q[3] <= tap_q[4];
                tap_q[4] <= tap_q[5];
                tap_q[5] <= lb1_rd_c;
                tap_q[6] <= tap_q[7];
                tap_q[7] <= tap_q[8];
                tap_q[8] <= pix_in;
                win_col  <= cur_col_c;
                win_row  <= cur_row_c;
            end
        end
    end

    // Pack taps onto the output bus.
    for (genvar k = 0; k < int'(N_TAPS); k++) begin : g_pack
        assign win_data[k*PIX_W +: PIX_W] = tap_q[k];
    end

endmodule

// File: tb/tb_window_3x3_line_buffer.sv
// Directed bench for window_3x3_line_buffer on a 4x4 frame; pixel = r*16+c.
module tb_window_3x3_line_buffer;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned IMG_W = 4;
    localparam int unsigned IMG_H = 4;
    localparam int unsigned COL_W = 2;
    localparam int unsigned ROW_W = 2;
    localparam int unsigned NPIX  = IMG_W * IMG_H;

    logic               clk;
    logic               rst_n;
    logic [PIX_W-1:0]   pix_in;
    logic               pix_valid;
    logic               sof;
    logic [9*PIX_W-1:0] win_data;
    logic               win_valid;
    logic [COL_W-1:0]   win_col;
    logic [ROW_W-1:0]   win_row;
    logic               frame_done;

    int tests_run;
    int tests_failed;

    window_3x3_line_buffer #(
        .PIX_W(PIX_W),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .sof       (sof),
        .win_data  (win_data),
        .win_valid (win_valid),
        .win_col   (win_col),
        .win_row   (win_row),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PIX_W-1:0] pix(input int r, input int c);
        return PIX_W'(r * 16 + c);
    endfunction

    // Expected window for an accept at (r,c): tap k = pixel(r-2+k/3, c-2+k%3).
    function automatic logic [9*PIX_W-1:0] exp_win(input int r, input int c);
        logic [9*PIX_W-1:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[k*PIX_W +: PIX_W] = pix(r - 2 + k / 3, c - 2 + k % 3);
        end
        return w;
    endfunction

    // Apply inputs, take one rising edge, settle 1 time unit past it.
    task automatic drive(input logic v, input logic s, input logic [PIX_W-1:0] p);
        pix_valid = v;
        sof       = s;
        pix_in    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 8'hA5);
        drive(1'b1, 1'b1, 8'h5A);
        tests_run++;
        if (win_data !== '0) begin
            tests_failed++;
            $display("FAIL reset win_data: got %h want 0", win_data);
        end
        tests_run++;
        if ({win_valid, frame_done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset strobes: got valid=%b done=%b want 0 0", win_valid, frame_done);
        end
        tests_run++;
        if ({win_row, win_col} !== '0) begin
            tests_failed++;
            $display("FAIL reset pos: got row=%0d col=%0d want 0 0", win_row, win_col);
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic test_continuous();
        int nvalid;
        int ndone;
        logic ev;
        nvalid = 0;
        ndone  = 0;
        for (int i = 0; i < int'(NPIX); i++) begin
            int r;
            int c;
            r  = i / 4;
            c  = i % 4;
            drive(1'b1, i == 0, pix(r, c));
            ev = (r >= 2) && (c >= 2);
            if (win_valid) nvalid++;
            if (frame_done) ndone++;
            tests_run++;
            if (win_valid !== ev) begin
                tests_failed++;
                $display("FAIL cont valid (%0d,%0d): got %b want %b", c, r, win_valid, ev);
            end
            if (ev) begin
                tests_run++;
                if (win_data !== exp_win(r, c) || win_col !== COL_W'(c) || win_row !== ROW_W'(r)) begin
                    tests_failed++;
                    $display("FAIL cont window (%0d,%0d): got %h c=%0d r=%0d want %h", c, r,
                             win_data, win_col, win_row, exp_win(r, c));
                end
            end
            if (i == 10) begin
                tests_run++;
                if (win_data !== 72'h22_21_20_12_11_10_02_01_00) begin
                    tests_failed++;
                    $display("FAIL first window: got %h want 222120121110020100", win_data);
                end
            end
            tests_run++;
            if (frame_done !== (i == 15)) begin
                tests_failed++;
                $display("FAIL cont frame_done at %0d: got %b want %b", i, frame_done, i == 15);
            end
        end
        tests_run++;
        if (nvalid != 4 || ndone != 1) begin
            tests_failed++;
            $display("FAIL cont counts: got valid=%0d done=%0d want 4 1", nvalid, ndone);
        end
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic test_stall();
        int nvalid;
        int ndone;
        logic ev;
        nvalid = 0;
        ndone  = 0;
        for (int i = 0; i < int'(NPIX); i++) begin
            int r;
            int c;
            r  = i / 4;
            c  = i % 4;
            drive(1'b1, i == 0, pix(r, c));
            ev = (r >= 2) && (c >= 2);
            if (win_valid) nvalid++;
            if (frame_done) ndone++;
            tests_run++;
            if (win_valid !== ev || (ev && win_data !== exp_win(r, c))) begin
                tests_failed++;
                $display("FAIL stall window (%0d,%0d): got v=%b %h want v=%b %h", c, r,
                         win_valid, win_data, ev, exp_win(r, c));
            end
            for (int s = 0; s < 3; s++) begin
                drive(1'b0, 1'b0, 8'hEE);
                tests_run++;
                if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stall strobe (%0d,%0d)+%0d: got v=%b d=%b want 0 0", c, r, s,
                             win_valid, frame_done);
                end
                tests_run++;
                if (win_col !== COL_W'(c) || win_row !== ROW_W'(r) || (ev && win_data !== exp_win(r, c))) begin
                    tests_failed++;
                    $display("FAIL stall hold (%0d,%0d)+%0d: got c=%0d r=%0d %h", c, r, s,
                             win_col, win_row, win_data);
                end
            end
        end
        tests_run++;
        if (nvalid != 4 || ndone != 1) begin
            tests_failed++;
            $display("FAIL stall counts: got valid=%0d done=%0d want 4 1", nvalid, ndone);
        end
    endtask

    task automatic test_line_wrap();
        for (int i = 0; i < int'(NPIX); i++) begin
            int r;
            int c;
            r = i / 4;
            c = i % 4;
            drive(1'b1, i == 0, pix(r, c));
            if (r >= 2 && c < 2) begin
                tests_run++;
                if (win_valid !== 1'b0 || win_col !== COL_W'(c) || win_row !== ROW_W'(r)) begin
                    tests_failed++;
                    $display("FAIL wrap (%0d,%0d): got v=%b c=%0d r=%0d want v=0", c, r,
                             win_valid, win_col, win_row);
                end
            end
        end
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic test_reset_mid();
        int nvalid;
        int ndone;
        logic ev;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, i == 0, pix(i / 4, i % 4));
        end
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 8'h55);
        tests_run++;
        if (win_data !== '0 || win_valid !== 1'b0 || frame_done !== 1'b0 ||
            win_col !== '0 || win_row !== '0) begin
            tests_failed++;
            $display("FAIL midreset outputs: got %h v=%b d=%b c=%0d r=%0d want all 0",
                     win_data, win_valid, frame_done, win_col, win_row);
        end
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'h77);
        tests_run++;
        if (win_col !== '0 || win_row !== '0 || win_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset counters: got c=%0d r=%0d v=%b want 0 0 0", win_col, win_row, win_valid);
        end
        nvalid = 0;
        ndone  = 0;
        for (int i = 0; i < int'(NPIX); i++) begin
            int r;
            int c;
            r  = i / 4;
            c  = i % 4;
            drive(1'b1, i == 0, pix(r, c));
            ev = (r >= 2) && (c >= 2);
            if (win_valid) nvalid++;
            if (frame_done) ndone++;
            tests_run++;
            if (win_valid !== ev || (ev && win_data !== exp_win(r, c))) begin
                tests_failed++;
                $display("FAIL midreset window (%0d,%0d): got v=%b %h want v=%b %h", c, r,
                         win_valid, win_data, ev, exp_win(r, c));
            end
        end
        tests_run++;
        if (nvalid != 4 || ndone != 1) begin
            tests_failed++;
            $display("FAIL midreset counts: got valid=%0d done=%0d want 4 1", nvalid, ndone);
        end
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic test_sof_mid();
        int nvalid;
        int ndone;
        logic ev;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, i == 0, pix(i / 4, i % 4));
        end
        // Would have been (2,1); sof restarts it as (0,0).
        drive(1'b1, 1'b1, pix(0, 0));
        tests_run++;
        if (win_col !== '0 || win_row !== '0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL sofmid restart: got c=%0d r=%0d v=%b d=%b want 0 0 0 0",
                     win_col, win_row, win_valid, frame_done);
        end
        nvalid = 0;
        ndone  = 0;
        for (int i = 1; i < int'(NPIX); i++) begin
            int r;
            int c;
            r  = i / 4;
            c  = i % 4;
            drive(1'b1, 1'b0, pix(r, c));
            ev = (r >= 2) && (c >= 2);
            if (win_valid) nvalid++;
            if (frame_done) ndone++;
            tests_run++;
            if (win_valid !== ev || (ev && win_data !== exp_win(r, c)) ||
                win_col !== COL_W'(c) || win_row !== ROW_W'(r)) begin
                tests_failed++;
                $display("FAIL sofmid window (%0d,%0d): got v=%b %h c=%0d r=%0d want v=%b %h", c, r,
                         win_valid, win_data, win_col, win_row, ev, exp_win(r, c));
            end
        end
        tests_run++;
        if (nvalid != 4 || ndone != 1) begin
            tests_failed++;
            $display("FAIL sofmid counts: got valid=%0d done=%0d want 4 1", nvalid, ndone);
        end
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic test_sof_idle();
        int nvalid;
        logic ev;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, i == 0, pix(i / 4, i % 4));
        end
        // sof without a pixel only rewinds the counters.
        drive(1'b0, 1'b1, 8'hCC);
        tests_run++;
        if (win_valid !== 1'b0 || win_col !== COL_W'(1) || win_row !== ROW_W'(1)) begin
            tests_failed++;
            $display("FAIL sofidle hold: got v=%b c=%0d r=%0d want 0 1 1", win_valid, win_col, win_row);
        end
        nvalid = 0;
        for (int i = 0; i < int'(NPIX); i++) begin
            int r;
            int c;
            r  = i / 4;
            c  = i % 4;
            drive(1'b1, 1'b0, pix(r, c));
            ev = (r >= 2) && (c >= 2);
            if (win_valid) nvalid++;
            tests_run++;
            if (win_valid !== ev || (ev && win_data !== exp_win(r, c)) ||
                win_col !== COL_W'(c) || win_row !== ROW_W'(r) || frame_done !== (i == 15)) begin
                tests_failed++;
                $display("FAIL sofidle (%0d,%0d): got v=%b %h c=%0d r=%0d d=%b", c, r,
                         win_valid, win_data, win_col, win_row, frame_done);
            end
        end
        tests_run++;
        if (nvalid != 4) begin
            tests_failed++;
            $display("FAIL sofidle count: got %0d want 4", nvalid);
        end
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        int nvalid;
        int ndone;
        logic ev;
        nvalid = 0;
        ndone  = 0;
        for (int i = 0; i < int'(2 * NPIX); i++) begin
            int r;
            int c;
            r  = (i % 16) / 4;
            c  = i % 4;
            drive(1'b1, i == 0, pix(r, c));
            ev = (r >= 2) && (c >= 2);
            if (win_valid) nvalid++;
            if (frame_done) ndone++;
            tests_run++;
            if (win_valid !== ev || (ev && win_data !== exp_win(r, c)) ||
                win_col !== COL_W'(c) || win_row !== ROW_W'(r) || frame_done !== (i % 16 == 15)) begin
                tests_failed++;
                $display("FAIL b2b step %0d (%0d,%0d): got v=%b %h c=%0d r=%0d d=%b", i, c, r,
                         win_valid, win_data, win_col, win_row, frame_done);
            end
        end
        tests_run++;
        if (nvalid != 8 || ndone != 2) begin
            tests_failed++;
            $display("FAIL b2b counts: got valid=%0d done=%0d want 8 2", nvalid, ndone);
        end
        drive(1'b0, 1'b0, '0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        pix_valid    = 1'b0;
        sof          = 1'b0;
        pix_in       = '0;
        test_reset();
        test_continuous();
        test_stall();
        test_line_wrap();
        test_reset_mid();
        test_sof_mid();
        test_sof_idle();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
